// File: rtl/clock_pkg.sv
// clock_pkg: field codes, calendar limits and date helpers shared by the
// clock_calendar_counter core.
package clock_pkg;

    localparam logic [2:0] FIELD_SEC   = 3'd0;
    localparam logic [2:0] FIELD_MIN   = 3'd1;
    localparam logic [2:0] FIELD_HOUR  = 3'd2;
    localparam logic [2:0] FIELD_DATE  = 3'd3;
    localparam logic [2:0] FIELD_MONTH = 3'd4;
    localparam logic [2:0] FIELD_YEAR  = 3'd5;

    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;

    localparam logic [3:0] SEC_TENS_MAX = 4'(MAX_SEC / 10);
    localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN / 10);

    localparam logic [4:0] MAX_HOUR  = 5'd23;
    localparam logic [3:0] MAX_MONTH = 4'd12;
    localparam logic [7:0] MAX_YEAR  = 8'd99;

    // Years 2000-2099 only, so every multiple of four is a leap year.
    function automatic logic [4:0] days_in_month(
        input logic [3:0] month,
        input logic [7:0] year
    );
        logic [4:0] d;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2: d = ((year % 8'd4) == 8'd0) ? 5'd29 : 5'd28;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    // Two-digit BCD increment, wrapping {tens_max,9} back to 00.
    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [3:0] tens_max
    );
        logic [7:0] r;
        if (v == {tens_max, 4'd9}) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_calendar_counter_tick_divider.sv
// tick_divider: counts 0..TICK_DIV-1 and fires a one-cycle tick on wrap;
// clear holds the count at zero and suppresses the tick.
module tick_divider #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_calendar_counter.sv
// clock_calendar_counter: sec..year timekeeping for 2000-2099 from a 1 Hz tick.
// Define CLOCK_SET_EN to enable the set_mode/set_field/set_inc edit path.
module clock_calendar_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter logic [7:0]  RST_YEAR = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_mode,
    input  logic [2:0] set_field,
    input  logic       set_inc,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic [3:0] min1,
    output logic [3:0] min2,
    output logic [4:0] hour,
    output logic [4:0] date,
    output logic [3:0] month,
    output logic [7:0] year,
    output logic       sec_pulse
);

    logic [3:0] sec1_q, sec1_d, sec2_q, sec2_d;
    logic [3:0] min1_q, min1_d, min2_q, min2_d;
    logic [4:0] hour_q, hour_d;
    logic [4:0] date_q, date_d;
    logic [3:0] month_q, month_d;
    logic [7:0] year_q, year_d;
    logic       sec_pulse_q, sec_pulse_d;

    logic       tick;
    logic       clear;
    logic       sec_wrap, min_wrap, hour_wrap, date_wrap, month_wrap;
    logic [4:0] dim;
    logic [7:0] sec_nx, min_nx;

`ifdef CLOCK_SET_EN
    assign clear = set_mode;
`else
    logic unused_set;
    assign unused_set = ^{set_mode, set_field, set_inc};
    assign clear = 1'b0;
`endif

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    assign dim        = days_in_month(month_q, year_q);
    assign sec_nx     = bcd_inc({sec2_q, sec1_q}, SEC_TENS_MAX);
    assign min_nx     = bcd_inc({min2_q, min1_q}, MIN_TENS_MAX);
    assign sec_wrap   = (sec_nx == 8'h00);
    assign min_wrap   = (min_nx == 8'h00);
    assign hour_wrap  = (hour_q >= MAX_HOUR);
    assign date_wrap  = (date_q >= dim);
    assign month_wrap = (month_q >= MAX_MONTH);

    always_comb begin
        sec1_d      = sec1_q;
        sec2_d      = sec2_q;
        min1_d      = min1_q;
        min2_d      = min2_q;
        hour_d      = hour_q;
        date_d      = date_q;
        month_d     = month_q;
        year_d      = year_q;
        sec_pulse_d = tick;

        if (tick) begin
            {sec2_d, sec1_d} = sec_nx;
            if (sec_wrap) begin
                {min2_d, min1_d} = min_nx;
                if (min_wrap) begin
                    hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
                    if (hour_wrap) begin
                        date_d = date_wrap ? 5'd1 : date_q + 5'd1;
                        if (date_wrap) begin
                            month_d = month_wrap ? 4'd1 : month_q + 4'd1;
                            if (month_wrap) begin
                                year_d = (year_q >= MAX_YEAR) ? 8'd0 : year_q + 8'd1;
                            end
                        end
                    end
                end
            end
        end
`ifdef CLOCK_SET_EN
        // Edits wrap within their own field only; month/year edits clamp date.
        else if (set_mode && set_inc) begin
            unique case (set_field)
                FIELD_SEC: begin
                    sec1_d = 4'd0;
                    sec2_d = 4'd0;
                end
                FIELD_MIN: begin
                    {min2_d, min1_d} = min_nx;
                end
                FIELD_HOUR: begin
                    hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
                end
                FIELD_DATE: begin
                    date_d = date_wrap ? 5'd1 : date_q + 5'd1;
                end
                FIELD_MONTH: begin
                    month_d = month_wrap ? 4'd1 : month_q + 4'd1;
                    if (date_q > days_in_month(month_d, year_q)) begin
                        date_d = days_in_month(month_d, year_q);
                    end
                end
                FIELD_YEAR: begin
                    year_d = (year_q >= MAX_YEAR) ? 8'd0 : year_q + 8'd1;
                    if (date_q > days_in_month(month_q, year_d)) begin
                        date_d = days_in_month(month_q, year_d);
                    end
                end
                default: begin
                end
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec1_q      <= 4'd0;
            sec2_q      <= 4'd0;
            min1_q      <= 4'd0;
            min2_q      <= 4'd0;
            hour_q      <= 5'd0;
            date_q      <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= RST_YEAR;
            sec_pulse_q <= 1'b0;
        end else begin
            sec1_q      <= sec1_d;
            sec2_q      <= sec2_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            hour_q      <= hour_d;
            date_q      <= date_d;
            month_q     <= month_d;
            year_q      <= year_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign sec1      = sec1_q;
    assign sec2      = sec2_q;
    assign min1      = min1_q;
    assign min2      = min2_q;
    assign hour      = hour_q;
    assign date      = date_q;
    assign month     = month_q;
    assign year      = year_q;
    assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_clock_calendar_counter.sv
// tb_clock_calendar_counter: directed checks of counting, carries, reset and
// (with CLOCK_SET_EN) the edit path, using TICK_DIV=4.
module tb_clock_calendar_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_mode = 1'b0;
    logic [2:0] set_field = 3'd0;
    logic       set_inc = 1'b0;
    logic [3:0] sec1, sec2, min1, min2, month;
    logic [4:0] hour, date;
    logic [7:0] year;
    logic       sec_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_calendar_counter #(
        .TICK_DIV (4),
        .RST_YEAR (8'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_mode  (set_mode),
        .set_field (set_field),
        .set_inc   (set_inc),
        .sec1      (sec1),
        .sec2      (sec2),
        .min1      (min1),
        .min2      (min2),
        .hour      (hour),
        .date      (date),
        .month     (month),
        .year      (year),
        .sec_pulse (sec_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Packed {year,month,date,hour,min2,min1,sec2,sec1} from decimal fields.
    function automatic logic [37:0] cal(int y, int mo, int d, int h, int mi, int s);
        return {8'(y), 4'(mo), 5'(d), 5'(h),
                4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_cal(input string tag, input int y, input int mo,
                             input int d, input int h, input int mi, input int s);
        check(tag, 64'({year, month, date, hour, min2, min1, sec2, sec1}),
              64'(cal(y, mo, d, h, mi, s)));
    endtask

    task automatic run_cycles(input int cyc, input string tag, input int exp);
        int p = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (sec_pulse) p++;
        end
        check(tag, 64'(p), 64'(exp));
    endtask

    task automatic wait_pulse(input string tag, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sec_pulse && n < 50);
        check(tag, 64'(n), 64'(exp));
    endtask

    task automatic edit(input logic [2:0] f, input int n);
        set_field = f;
        repeat (n) begin
            set_inc = 1'b1;
            @(negedge clk);
        end
        set_inc = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_cal("rst_cal", 0, 1, 1, 0, 0, 0);
        check("rst_pulse", 64'(sec_pulse), 64'(0));

        rst_n = 1'b1;
        run_cycles(3, "no_early_pulse", 0);
        @(negedge clk);
        check("first_pulse", 64'(sec_pulse), 64'(1));
        check_cal("first_sec", 0, 1, 1, 0, 0, 1);

        run_cycles(2, "mid_count", 0);
        rst_n = 1'b0;
        #1;
        check_cal("async_rst", 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("restart_len", 4);
        check_cal("restart_sec", 0, 1, 1, 0, 0, 1);

        run_cycles(4 * 58, "pulses_58", 58);
        check_cal("sec_59", 0, 1, 1, 0, 0, 59);
        run_cycles(4, "pulses_1", 1);
        check_cal("min_carry", 0, 1, 1, 0, 1, 0);
        run_cycles(4 * 3540, "pulses_3540", 3540);
        check_cal("hour_carry", 0, 1, 1, 1, 0, 0);

        set_field = 3'd5;
        set_inc = 1'b1;
        run_cycles(4, "inc_idle_pulse", 1);
        set_inc = 1'b0;
        check_cal("inc_idle", 0, 1, 1, 1, 0, 1);

`ifndef CLOCK_SET_EN
        set_mode = 1'b1;
        set_field = 3'd2;
        set_inc = 1'b1;
        run_cycles(8, "noset_pulses", 2);
        set_inc = 1'b0;
        set_mode = 1'b0;
        check_cal("noset_cal", 0, 1, 1, 1, 0, 3);
`else
        rst_n = 1'b0;
        set_mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        edit(3'd5, 99);
        edit(3'd4, 11);
        edit(3'd3, 30);
        edit(3'd2, 23);
        edit(3'd1, 59);
        check_cal("preset_eoc", 99, 12, 31, 23, 59, 0);
        run_cycles(12, "frozen_pulses", 0);
        check_cal("frozen_cal", 99, 12, 31, 23, 59, 0);
        set_mode = 1'b0;
        wait_pulse("release_len", 4);
        run_cycles(4 * 58, "eoc_pulses", 58);
        check_cal("eoc_59", 99, 12, 31, 23, 59, 59);
        run_cycles(4, "wrap_pulse", 1);
        check_cal("year_wrap", 0, 1, 1, 0, 0, 0);
        set_mode = 1'b1;
        @(negedge clk);
        check("pulse_width", 64'(sec_pulse), 64'(0));

        edit(3'd5, 24);
        edit(3'd4, 1);
        edit(3'd3, 27);
        edit(3'd2, 23);
        edit(3'd1, 59);
        check_cal("preset_leap", 24, 2, 28, 23, 59, 0);
        set_mode = 1'b0;
        run_cycles(4 * 60, "leap_pulses", 60);
        check_cal("leap_day", 24, 2, 29, 0, 0, 0);

        set_mode = 1'b1;
        edit(3'd3, 1);
        check_cal("leap_date_wrap", 24, 2, 1, 0, 0, 0);
        edit(3'd4, 11);
        edit(3'd3, 30);
        check_cal("jan31", 24, 1, 31, 0, 0, 0);
        edit(3'd4, 1);
        check_cal("clamp_leap", 24, 2, 29, 0, 0, 0);
        edit(3'd5, 1);
        check_cal("clamp_year", 25, 2, 28, 0, 0, 0);
        edit(3'd1, 60);
        check_cal("min_wrap", 25, 2, 28, 0, 0, 0);

        edit(3'd5, 98);
        edit(3'd4, 11);
        edit(3'd3, 3);
        check_cal("jan31_23", 23, 1, 31, 0, 0, 0);
        edit(3'd4, 1);
        check_cal("clamp_common", 23, 2, 28, 0, 0, 0);
        edit(3'd3, 1);
        check_cal("feb_wrap", 23, 2, 1, 0, 0, 0);
        edit(3'd3, 27);
        edit(3'd2, 23);
        edit(3'd1, 59);
        set_mode = 1'b0;
        run_cycles(4 * 60, "day_pulses", 60);
        check_cal("nonleap_day", 23, 3, 1, 0, 0, 0);

        run_cycles(12, "three_pulses", 3);
        set_mode = 1'b1;
        edit(3'd6, 2);
        check_cal("field6_noop", 23, 3, 1, 0, 0, 3);
        edit(3'd0, 1);
        check_cal("sec_clear", 23, 3, 1, 0, 0, 0);
        set_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
